vga_sync_decoder: RTL and testbench
===================================

Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the VGA timing engine. Samples an incoming hs/vs/r/g/b stream on pixel strobes and recovers active-video x/y coordinates, a data-enable and registered colour.
- Measures line and frame lengths, runs a lock state machine against nominal 640x480@60 timing, and flags timing errors.
- Used as an on-board loopback checker for the display path and as the front end for future video capture.

Parameters:
- H_SYNC, 96, hsync pulse width in pixels
- H_BP, 48, horizontal back porch
- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 800, nominal pixels per line
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch
- V_ACTIVE, 480, active lines
- V_TOTAL, 525, nominal lines per frame
- SYNC_POL, 0, sync asserted level (0 = active-low)
- LOCK_FRAMES, 2, consecutive good frames required for lock

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pix_en  in  1  pixel strobe; all sampling and counting happens only on cycles with pix_en=1
- hs  in  1  incoming horizontal sync
- vs  in  1  incoming vertical sync
- r_in, g_in, b_in  in  3 each  incoming colour
- x  out  11  active-region column, 0..H_ACTIVE-1
- y  out  11  active-region row, 0..V_ACTIVE-1
- de  out  1  active video valid
- r, g, b  out  3 each  registered colour, forced to 0 when de=0
- locked  out  1  timing lock
- frame_start  out  1  one-clk pulse on each vs leading edge
- err  out  1  one-clk pulse on any timing violation while ACQUIRE or LOCKED
- h_meas  out  11  last measured line length
- v_meas  out  11  last measured frame length

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0; counters 0; sync history registers set to the deasserted level; state SEARCH.
- On each pix_en cycle, hs/vs/rgb are registered. A leading edge is a previous sample deasserted and the current sample asserted (level per SYNC_POL).
- hcnt:
  - On hs leading edge: h_meas <= hcnt+1, then hcnt <= 0.
  - Otherwise hcnt <= hcnt+1, saturating at 2047.
- vcnt:
  - On vs leading edge: v_meas <= vcnt+1, then vcnt <= 0.
  - Otherwise, on hs leading edge, vcnt <= vcnt+1, saturating at 2047.
  - If vs and hs edges coincide, the vs edge wins.
- Active window: hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] (144..783) and vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1] (35..514).
- de = locked AND in window. When de=1: x = hcnt-144, y = vcnt-35, and rgb = the sampled colour. When de=0: x=y=rgb=0.
- Latency: de/x/y/rgb update on the clk edge after the pix_en sample (1 pixel). Outputs hold between strobes.
- frame_start pulses for exactly one clk on the vs-edge sample, in every state.
- line_bad (sticky): set by any hs edge with measured length != H_TOTAL; cleared at each vs edge.
- A frame is good if, at its closing vs edge, measured frame length == V_TOTAL and line_bad == 0.
- FSM:
  - SEARCH: vs edge -> ACQUIRE with good_cnt=0.
  - ACQUIRE, at vs edge: good frame -> good_cnt+1; good_cnt reaching LOCK_FRAMES -> LOCKED. Bad frame -> good_cnt=0, err pulse, stay in ACQUIRE.
  - LOCKED: any hs edge with length != H_TOTAL, or a bad frame at a vs edge -> ACQUIRE, good_cnt=0, err pulse, locked=0 on the same edge.
  - Any state: hcnt reaching 2047 (sync lost) -> SEARCH. err pulses if the state was ACQUIRE or LOCKED.
- locked=1 only in LOCKED.
- The first vs edge after reset or SEARCH only starts measurement; that partial frame is never judged.
- pix_en=0: no state change. Gaps of any length between strobes are legal.

Test Plan:
- Nominal 800x525 timing, pix_en every 2nd clk, 4 frames -> locked rises on the 3rd vs edge. The 4th frame gives exactly 307200 de pixels. The first de has x=0,y=0 at hcnt=144, vcnt=35; the last has x=639,y=479. h_meas=800, v_meas=525.
- While locked, one 799-pixel line -> err pulses once, locked and de drop at that hs edge. Relock after 2 further good frames.
- While locked, a frame of 524 lines -> err at the vs edge, locked=0, state ACQUIRE.
- hs and vs held deasserted -> after 2048 strobes locked=0, one err pulse, state SEARCH; frame_start stays quiet.
- SYNC_POL=1 with inverted syncs -> identical lock timing and coordinates as the first scenario. Coincident hs/vs edges -> vcnt=0.
- rst asserted mid-active-line for 1 clk -> next clk all outputs 0 and state SEARCH. Relock requires 3 vs edges.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: measures line/frame lengths, locks onto nominal
// timing and recovers active-video coordinates, data-enable and colour.
module vga_sync_decoder #(
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int SYNC_POL    = 0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        hs,
  input  logic        vs,
  input  logic [2:0]  r_in,
  input  logic [2:0]  g_in,
  input  logic [2:0]  b_in,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        de,
  output logic [2:0]  r,
  output logic [2:0]  g,
  output logic [2:0]  b,
  output logic        locked,
  output logic        frame_start,
  output logic        err,
  output logic [10:0] h_meas,
  output logic [10:0] v_meas
);

  localparam int unsigned GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic            ASSERTED = 1'(SYNC_POL);
  localparam logic [10:0]     H_LO     = 11'(H_SYNC + H_BP);
  localparam logic [10:0]     H_HI     = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [10:0]     V_LO     = 11'(V_SYNC + V_BP);
  localparam logic [10:0]     V_HI     = 11'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [11:0]     H_LEN    = 12'(H_TOTAL);
  localparam logic [11:0]     V_LEN    = 12'(V_TOTAL);
  localparam logic [GW-1:0]   LOCK_CNT = GW'(LOCK_FRAMES);
  localparam logic [10:0]     CNT_MAX  = 11'h7FF;

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t        state, stateNext;
  logic [GW-1:0] goodCnt, goodCntNext;
  logic [10:0]   hcnt, vcnt, hcntNext, vcntNext;
  logic          hsPrev, vsPrev;
  logic          lineBad, lineBadNext;
  logic          hsEdge, vsEdge, hBad, frameBad, syncLost, errNext, deNext;
  logic [11:0]   hLen, vLen;

  // Edge detection, counter update and timing judgement for the current strobe
  always_comb begin
    hsEdge   = pix_en && (hsPrev != ASSERTED) && (hs == ASSERTED);
    vsEdge   = pix_en && (vsPrev != ASSERTED) && (vs == ASSERTED);
    hLen     = {1'b0, hcnt} + 12'd1;
    vLen     = {1'b0, vcnt} + 12'd1;
    hBad     = hsEdge && (hLen != H_LEN);
    frameBad = (vLen != V_LEN) || lineBad || hBad;
    syncLost = pix_en && !hsEdge && (hcnt == CNT_MAX - 11'd1);

    hcntNext = hcnt;
    if (pix_en) begin
      if (hsEdge)                hcntNext = 11'd0;
      else if (hcnt != CNT_MAX)  hcntNext = hcnt + 11'd1;
    end

    vcntNext = vcnt;
    if (vsEdge)                            vcntNext = 11'd0;
    else if (hsEdge && (vcnt != CNT_MAX))  vcntNext = vcnt + 11'd1;

    lineBadNext = lineBad;
    if (vsEdge)     lineBadNext = 1'b0;
    else if (hBad)  lineBadNext = 1'b1;
  end

  // Lock state machine: next state, good-frame count and error pulse
  always_comb begin
    stateNext   = state;
    goodCntNext = goodCnt;
    errNext     = 1'b0;
    if (syncLost) begin
      stateNext   = SEARCH;
      goodCntNext = '0;
      errNext     = (state != SEARCH);
    end else begin
      case (state)
        SEARCH: begin
          if (vsEdge) begin
            stateNext   = ACQUIRE;
            goodCntNext = '0;
          end
        end
        ACQUIRE: begin
          if (vsEdge) begin
            if (frameBad) begin
              goodCntNext = '0;
              errNext     = 1'b1;
            end else if (goodCnt + GW'(1) == LOCK_CNT) begin
              stateNext   = LOCKED;
              goodCntNext = goodCnt + GW'(1);
            end else begin
              goodCntNext = goodCnt + GW'(1);
            end
          end
        end
        LOCKED: begin
          if (hBad || (vsEdge && frameBad)) begin
            stateNext   = ACQUIRE;
            goodCntNext = '0;
            errNext     = 1'b1;
          end
        end
        default: stateNext = SEARCH;
      endcase
    end
    deNext = (stateNext == LOCKED) &&
             (hcntNext >= H_LO) && (hcntNext <= H_HI) &&
             (vcntNext >= V_LO) && (vcntNext <= V_HI);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SEARCH;
      goodCnt <= '0;
    end else begin
      state   <= stateNext;
      goodCnt <= goodCntNext;
    end
  end

  // Sampled history, counters and registered outputs; pulses clear on idle clocks
  always_ff @(posedge clk) begin
    if (rst) begin
      hsPrev      <= ~ASSERTED;
      vsPrev      <= ~ASSERTED;
      hcnt        <= '0;
      vcnt        <= '0;
      lineBad     <= 1'b0;
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      err         <= 1'b0;
      h_meas      <= '0;
      v_meas      <= '0;
    end else begin
      frame_start <= vsEdge;
      err         <= errNext;
      locked      <= (stateNext == LOCKED);
      if (pix_en) begin
        hsPrev  <= hs;
        vsPrev  <= vs;
        hcnt    <= hcntNext;
        vcnt    <= vcntNext;
        lineBad <= lineBadNext;
        de      <= deNext;
        x       <= deNext ? hcntNext - H_LO : 11'd0;
        y       <= deNext ? vcntNext - V_LO : 11'd0;
        r       <= deNext ? r_in : 3'd0;
        g       <= deNext ? g_in : 3'd0;
        b       <= deNext ? b_in : 3'd0;
        if (hsEdge) h_meas <= hLen[10:0];
        if (vsEdge) v_meas <= vLen[10:0];
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled-down raster; two instances (active-low and
// active-high syncs) are compared against a per-strobe reference model.
module tb_vga_sync_decoder;

  localparam int HS = 4, HB = 3, HA = 8, HT = 20;
  localparam int VS = 2, VB = 2, VA = 5, VT = 12;
  localparam int LF = 2;

  logic clk = 1'b0;
  logic rst, pix_en, hs0, vs0, hs1, vs1;
  logic [2:0] r_in, g_in, b_in;
  logic [10:0] x0, y0, hm0, vm0, x1, y1, hm1, vm1;
  logic [2:0] r0, g0, b0, r1, g1, b1;
  logic de0, lk0, fs0, er0, de1, lk1, fs1, er1;

  always #5 clk = ~clk;

  vga_sync_decoder #(.H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_TOTAL(VT), .SYNC_POL(0), .LOCK_FRAMES(LF))
  dut0 (.clk(clk), .rst(rst), .pix_en(pix_en), .hs(hs0), .vs(vs0),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .x(x0), .y(y0), .de(de0),
    .r(r0), .g(g0), .b(b0), .locked(lk0), .frame_start(fs0), .err(er0),
    .h_meas(hm0), .v_meas(vm0));

  vga_sync_decoder #(.H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_TOTAL(VT), .SYNC_POL(1), .LOCK_FRAMES(LF))
  dut1 (.clk(clk), .rst(rst), .pix_en(pix_en), .hs(hs1), .vs(vs1),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .x(x1), .y(y1), .de(de1),
    .r(r1), .g(g1), .b(b1), .locked(lk1), .frame_start(fs1), .err(er1),
    .h_meas(hm1), .v_meas(vm1));

  int nAssert = 0, nFail = 0;
  int mm = 0;
  string mmFirst = "";
  int gapFixed = 1;
  int errSeen, fsSeen, deSeen, firstX, firstY, lastX, lastY;
  bit haveFirst;

  // Reference model: position since last sync edges plus lock status (0 search, 1 acquire, 2 locked)
  bit mHs, mVs, mLineBad;
  int mH, mV, mSt, mGood;
  int eX, eY, eR, eG, eB, eHm, eVm;
  bit eDe, eLk, eFs, eErr;

  function automatic logic [56:0] pk(input logic [10:0] px, input logic [10:0] py,
      input logic pde, input logic [2:0] pr, input logic [2:0] pg, input logic [2:0] pb,
      input logic plk, input logic pfs, input logic per,
      input logic [10:0] phm, input logic [10:0] pvm);
    return {px, py, pde, pr, pg, pb, plk, pfs, per, phm, pvm};
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    nAssert++;
    if (got != want) begin
      nFail++;
      $display("FAIL %s: got %0d, required %0d", nm, got, want);
    end
  endtask

  task automatic model_reset();
    mHs = 0; mVs = 0; mLineBad = 0; mH = 0; mV = 0; mSt = 0; mGood = 0;
    eX = 0; eY = 0; eR = 0; eG = 0; eB = 0; eHm = 0; eVm = 0;
    eDe = 0; eLk = 0; eFs = 0; eErr = 0;
  endtask

  task automatic model_step(input bit hA, input bit vA, input logic [2:0] cr,
      input logic [2:0] cg, input logic [2:0] cb);
    bit hE, vE, hBad, fBad, lost;
    int hLen, vLen;
    hE = hA && !mHs;
    vE = vA && !mVs;
    mHs = hA; mVs = vA;
    hLen = mH + 1;
    vLen = mV + 1;
    hBad = hE && (hLen != HT);
    lost = !hE && (mH == 2046);
    eErr = 0;
    eFs = vE;
    if (lost) begin
      eErr = (mSt != 0); mSt = 0; mGood = 0;
    end else if (vE) begin
      fBad = (vLen != VT) || mLineBad || hBad;
      if (mSt == 0) begin
        mSt = 1; mGood = 0;
      end else if (fBad) begin
        mSt = 1; mGood = 0; eErr = 1;
      end else if (mSt == 1) begin
        mGood++;
        if (mGood == LF) mSt = 2;
      end
    end else if (hBad && mSt == 2) begin
      mSt = 1; mGood = 0; eErr = 1;
    end
    if (vE) mLineBad = 0;
    else if (hBad) mLineBad = 1;
    if (hE) eHm = hLen % 2048;
    if (vE) eVm = vLen % 2048;
    mH = hE ? 0 : ((mH < 2047) ? mH + 1 : 2047);
    if (vE) mV = 0;
    else if (hE && mV < 2047) mV++;
    eLk = (mSt == 2);
    eDe = eLk && mH >= HS + HB && mH < HS + HB + HA && mV >= VS + VB && mV < VS + VB + VA;
    eX = eDe ? mH - (HS + HB) : 0;
    eY = eDe ? mV - (VS + VB) : 0;
    eR = eDe ? int'(cr) : 0;
    eG = eDe ? int'(cg) : 0;
    eB = eDe ? int'(cb) : 0;
  endtask

  task automatic check_now();
    logic [56:0] e, a0, a1;
    e = pk(11'(eX), 11'(eY), eDe, 3'(eR), 3'(eG), 3'(eB), eLk, eFs, eErr, 11'(eHm), 11'(eVm));
    a0 = pk(x0, y0, de0, r0, g0, b0, lk0, fs0, er0, hm0, vm0);
    a1 = pk(x1, y1, de1, r1, g1, b1, lk1, fs1, er1, hm1, vm1);
    if (a0 != e) begin
      mm++;
      if (mmFirst == "") mmFirst = $sformatf("pol0 at %0t got %h need %h", $time, a0, e);
    end
    if (a1 != e) begin
      mm++;
      if (mmFirst == "") mmFirst = $sformatf("pol1 at %0t got %h need %h", $time, a1, e);
    end
  endtask

  task automatic chk_model(input string nm);
    if (mm != 0) $display("  first difference: %s", mmFirst);
    chk(nm, mm, 0);
    mm = 0;
    mmFirst = "";
  endtask

  // One pixel strobe, output check, then idle clocks during which outputs must hold
  task automatic strobe(input bit hA, input bit vA);
    logic [2:0] cr, cg, cb;
    int n;
    cr = 3'($urandom); cg = 3'($urandom); cb = 3'($urandom);
    hs0 = ~hA; vs0 = ~vA; hs1 = hA; vs1 = vA;
    r_in = cr; g_in = cg; b_in = cb;
    pix_en = 1'b1;
    model_step(hA, vA, cr, cg, cb);
    @(negedge clk);
    pix_en = 1'b0;
    check_now();
    if (er0) errSeen++;
    if (fs0) fsSeen++;
    if (de0) begin
      deSeen++;
      if (!haveFirst) begin
        firstX = int'(x0); firstY = int'(y0); haveFirst = 1;
      end
      lastX = int'(x0); lastY = int'(y0);
    end
    n = (gapFixed >= 0) ? gapFixed : int'($urandom_range(0, 3));
    eFs = 0; eErr = 0;
    repeat (n) begin
      @(negedge clk);
      check_now();
    end
  endtask

  task automatic send_frame(input int nLines, input int badLine, input int badLen,
      input int stopAt);
    int cnt, len;
    cnt = 0;
    for (int l = 0; l < nLines; l++) begin
      len = (l == badLine) ? badLen : HT;
      for (int p = 0; p < len; p++) begin
        if (stopAt >= 0 && cnt >= stopAt) return;
        strobe(p < HS, l < VS);
        cnt++;
      end
    end
  endtask

  task automatic clear_seen();
    errSeen = 0; fsSeen = 0; deSeen = 0; haveFirst = 0;
    firstX = -1; firstY = -1; lastX = -1; lastY = -1;
  endtask

  typedef struct {
    int nLines;
    int badLine;
    int badLen;
    bit expLock;
    int expErrs;
    int expHm;
    int expVm;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{VT, -1, 0,  1'b0, 0, HT, 1};
    tbl[1] = '{VT, -1, 0,  1'b0, 0, HT, VT};
    tbl[2] = '{VT, -1, 0,  1'b1, 0, HT, VT};
    tbl[3] = '{VT, -1, 0,  1'b1, 0, HT, VT};
    tbl[4] = '{VT, 5,  19, 1'b0, 1, HT, VT};
    tbl[5] = '{VT, -1, 0,  1'b0, 1, HT, VT};
    tbl[6] = '{VT, -1, 0,  1'b0, 0, HT, VT};
    tbl[7] = '{VT, -1, 0,  1'b1, 0, HT, VT};
    tbl[8] = '{VT - 1, -1, 0, 1'b1, 0, HT, VT};
    tbl[9] = '{VT, -1, 0,  1'b0, 1, HT, VT - 1};

    rst = 1'b1; pix_en = 1'b0;
    hs0 = 1'b1; vs0 = 1'b1; hs1 = 1'b0; vs1 = 1'b0;
    r_in = '0; g_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_pol0", int'(pk(x0, y0, de0, r0, g0, b0, lk0, fs0, er0, hm0, vm0) != 57'd0), 0);
    chk("reset_outputs_pol1", int'(pk(x1, y1, de1, r1, g1, b1, lk1, fs1, er1, hm1, vm1) != 57'd0), 0);
    rst = 1'b0;
    model_reset();

    // Nominal lock, line-length error, short frame; pix_en every second clock
    gapFixed = 1;
    for (int i = 0; i < 10; i++) begin
      clear_seen();
      send_frame(tbl[i].nLines, tbl[i].badLine, tbl[i].badLen, -1);
      chk($sformatf("frame%0d_locked", i), int'(lk0), int'(tbl[i].expLock));
      chk($sformatf("frame%0d_err_pulses", i), errSeen, tbl[i].expErrs);
      chk($sformatf("frame%0d_h_meas", i), int'(hm0), tbl[i].expHm);
      chk($sformatf("frame%0d_v_meas", i), int'(vm0), tbl[i].expVm);
      chk($sformatf("frame%0d_frame_start", i), fsSeen, 1);
      if (i == 3) begin
        chk("frame3_de_pixels", deSeen, HA * VA);
        chk("frame3_first_x", firstX, 0);
        chk("frame3_first_y", firstY, 0);
        chk("frame3_last_x", lastX, HA - 1);
        chk("frame3_last_y", lastY, VA - 1);
      end
    end
    chk_model("model_table_frames");

    // Syncs stop: counter saturation drops back to search with a single error
    clear_seen();
    gapFixed = -1;
    for (int i = 0; i < 2100; i++) strobe(1'b0, 1'b0);
    chk("syncloss_err_pulses", errSeen, 1);
    chk("syncloss_frame_start", fsSeen, 0);
    chk("syncloss_locked", int'(lk0), 0);
    chk_model("model_syncloss");

    // Randomised timing jitter and strobe gaps
    for (int f = 0; f < 10; f++) begin
      int nl, bl, blen;
      nl = VT;
      if ($urandom_range(0, 3) == 0) nl = ($urandom_range(0, 1) == 1) ? VT + 1 : VT - 1;
      bl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
      blen = ($urandom_range(0, 1) == 1) ? HT + 1 : HT - 1;
      send_frame(nl, bl, blen, -1);
    end
    chk_model("model_random_frames");

    // Relock, then a one-clock reset in the middle of an active line
    gapFixed = 1;
    for (int i = 0; i < 3; i++) send_frame(VT, -1, 0, -1);
    clear_seen();
    send_frame(VT, -1, 0, 6 * HT + 10);
    chk("midline_de_before_reset", int'(de0), 1);
    rst = 1'b1; pix_en = 1'b1;
    hs0 = 1'b1; vs0 = 1'b1; hs1 = 1'b0; vs1 = 1'b0;
    @(negedge clk);
    rst = 1'b0; pix_en = 1'b0;
    model_reset();
    chk("midline_reset_pol0", int'(pk(x0, y0, de0, r0, g0, b0, lk0, fs0, er0, hm0, vm0) != 57'd0), 0);
    chk("midline_reset_pol1", int'(pk(x1, y1, de1, r1, g1, b1, lk1, fs1, er1, hm1, vm1) != 57'd0), 0);
    for (int i = 0; i < 3; i++) begin
      send_frame(VT, -1, 0, -1);
      chk($sformatf("relock%0d_locked", i), int'(lk0), (i == 2) ? 1 : 0);
    end
    chk_model("model_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
